// File: rtl/l15_coherence_agent.sv
// L1.5 coherence endpoint: core requests to msg1, msg2 responses
// and forwards consumed, forward acks queued onto msg3.
module l15_coherence_agent #(
  parameter int CACHE_ID   = 0,
  parameter int OWNER_BITS = 3,
  parameter int MSG_WIDTH  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 16,
  parameter int MESI_WIDTH = 2,
  parameter int DIR_WIDTH  = 2**OWNER_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_req_store,
  input  logic [TAG_WIDTH-1:0]  core_req_tag,
  input  logic [DATA_WIDTH-1:0] core_req_data,
  output logic                  core_resp_valid,
  output logic [DATA_WIDTH-1:0] core_resp_data,
  output logic [MSG_WIDTH-1:0]  msg1_type,
  output logic [DATA_WIDTH-1:0] msg1_data,
  output logic [TAG_WIDTH-1:0]  msg1_tag,
  output logic [OWNER_BITS-1:0] msg1_source,
  input  logic [MSG_WIDTH-1:0]  msg2_type,
  input  logic [DATA_WIDTH-1:0] msg2_data,
  input  logic [TAG_WIDTH-1:0]  msg2_tag,
  input  logic [MESI_WIDTH-1:0] mesi_send,
  input  logic [OWNER_BITS-1:0] cache_owner,
  input  logic [DIR_WIDTH-1:0]  share_list,
  output logic [MSG_WIDTH-1:0]  msg3_type,
  output logic [DATA_WIDTH-1:0] msg3_data,
  output logic [TAG_WIDTH-1:0]  msg3_tag,
  output logic [OWNER_BITS-1:0] msg3_source,
  input  logic                  msg3_grant,
  output logic                  ack_ovf
);

  localparam logic [MSG_WIDTH-1:0] NONE      = MSG_WIDTH'(0);
  localparam logic [MSG_WIDTH-1:0] LOAD_REQ  = MSG_WIDTH'(1);
  localparam logic [MSG_WIDTH-1:0] STORE_REQ = MSG_WIDTH'(2);
  localparam logic [MSG_WIDTH-1:0] WB_REQ    = MSG_WIDTH'(3);
  localparam logic [MSG_WIDTH-1:0] LOAD_ACK  = MSG_WIDTH'(4);
  localparam logic [MSG_WIDTH-1:0] STORE_ACK = MSG_WIDTH'(5);
  localparam logic [MSG_WIDTH-1:0] WB_ACK    = MSG_WIDTH'(6);
  localparam logic [MSG_WIDTH-1:0] LOAD_FWD  = MSG_WIDTH'(7);
  localparam logic [MSG_WIDTH-1:0] STORE_FWD = MSG_WIDTH'(8);
  localparam logic [MSG_WIDTH-1:0] INV_FWD   = MSG_WIDTH'(9);
  localparam logic [MSG_WIDTH-1:0] LOAD_FA   = MSG_WIDTH'(10);
  localparam logic [MSG_WIDTH-1:0] STORE_FA  = MSG_WIDTH'(11);
  localparam logic [MSG_WIDTH-1:0] INV_FA    = MSG_WIDTH'(12);

  localparam logic [MESI_WIDTH-1:0] MI = MESI_WIDTH'(0);
  localparam logic [MESI_WIDTH-1:0] MS = MESI_WIDTH'(1);
  localparam logic [MESI_WIDTH-1:0] ME = MESI_WIDTH'(2);
  localparam logic [MESI_WIDTH-1:0] MM = MESI_WIDTH'(3);

  localparam logic [OWNER_BITS-1:0] ID = OWNER_BITS'(CACHE_ID);
  localparam logic [DIR_WIDTH-1:0]  ID_BIT =
    DIR_WIDTH'(1) << CACHE_ID;

  typedef enum logic [2:0] {
    IDLE, WB, WB_WAIT, REQ, WAIT
  } state_t;

  state_t state_q, state_d;

  logic [TAG_WIDTH-1:0]  line_tag;
  logic [MESI_WIDTH-1:0] line_mesi;
  logic [DATA_WIDTH-1:0] line_data;

  logic                  req_store;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [DATA_WIDTH-1:0] req_data;

  logic own, inv_sel;
  logic ld_fwd, st_fwd, inv_fwd, fwd, fwd_hit;
  logic wb_ack, done, ld_done;
  logic accept, core_hit, wr_ok;
  logic acc_ld_hit, acc_st_hit, acc_wb, acc_req;

  assign own     = cache_owner == ID;
  assign inv_sel = |(share_list & ID_BIT);
  assign ld_fwd  = own && msg2_type == LOAD_FWD;
  assign st_fwd  = own && msg2_type == STORE_FWD;
  assign inv_fwd = inv_sel && msg2_type == INV_FWD;
  assign fwd     = ld_fwd || st_fwd || inv_fwd;
  assign fwd_hit = msg2_tag == line_tag && line_mesi != MI;

  assign wb_ack  = state_q == WB_WAIT && own &&
                   msg2_type == WB_ACK;
  assign ld_done = msg2_type == LOAD_ACK;
  assign done    = state_q == WAIT && own &&
                   msg2_tag == req_tag &&
                   (ld_done || msg2_type == STORE_ACK);

  assign core_req_ready = !rst && state_q == IDLE && !fwd;
  assign accept   = core_req_valid && core_req_ready;
  assign core_hit = core_req_tag == line_tag && line_mesi != MI;
  assign wr_ok    = line_mesi == ME || line_mesi == MM;

  assign acc_ld_hit = accept && !core_req_store && core_hit;
  assign acc_st_hit = accept && core_req_store &&
                      core_hit && wr_ok;
  assign acc_wb     = accept && core_req_tag != line_tag &&
                      line_mesi == MM;
  assign acc_req    = accept && !acc_ld_hit &&
                      !acc_st_hit && !acc_wb;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc_wb)       state_d = WB;
        else if (acc_req) state_d = REQ;
      end
      WB:      state_d = WB_WAIT;
      WB_WAIT: if (wb_ack) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [MSG_WIDTH-1:0]  m1_type_d;
  logic [TAG_WIDTH-1:0]  m1_tag_d;
  logic [DATA_WIDTH-1:0] m1_data_d;
  logic                  resp_v_d;
  logic [DATA_WIDTH-1:0] resp_data_d;

  always_comb begin
    m1_type_d   = NONE;
    m1_tag_d    = '0;
    m1_data_d   = '0;
    resp_v_d    = 1'b0;
    resp_data_d = core_resp_data;
    unique case (1'b1)
      acc_ld_hit: begin
        resp_v_d    = 1'b1;
        resp_data_d = line_data;
      end
      acc_st_hit: begin
        resp_v_d    = 1'b1;
        resp_data_d = core_req_data;
      end
      acc_wb: begin
        m1_type_d = WB_REQ;
        m1_tag_d  = line_tag;
        m1_data_d = line_data;
      end
      acc_req: begin
        m1_type_d = core_req_store ? STORE_REQ : LOAD_REQ;
        m1_tag_d  = core_req_tag;
        m1_data_d = core_req_store ? core_req_data : '0;
      end
      wb_ack: begin
        m1_type_d = req_store ? STORE_REQ : LOAD_REQ;
        m1_tag_d  = req_tag;
        m1_data_d = req_data;
      end
      done: begin
        resp_v_d    = 1'b1;
        resp_data_d = ld_done ? msg2_data : req_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg1_type       <= NONE;
      msg1_tag        <= '0;
      msg1_data       <= '0;
      msg1_source     <= '0;
      core_resp_valid <= 1'b0;
      core_resp_data  <= '0;
    end else begin
      msg1_type       <= m1_type_d;
      msg1_tag        <= m1_tag_d;
      msg1_data       <= m1_data_d;
      msg1_source     <= (m1_type_d != NONE) ? ID : '0;
      core_resp_valid <= resp_v_d;
      core_resp_data  <= resp_data_d;
    end
  end

  // Forwards and completions never share a cycle, so order is benign
  always_ff @(posedge clk) begin
    if (rst) begin
      line_tag  <= '0;
      line_mesi <= MI;
      line_data <= '0;
      req_store <= 1'b0;
      req_tag   <= '0;
      req_data  <= '0;
    end else begin
      if (fwd && fwd_hit) begin
        line_mesi <= ld_fwd ? MS : MI;
      end else if (acc_st_hit) begin
        line_data <= core_req_data;
        line_mesi <= MM;
      end else if (wb_ack) begin
        line_mesi <= MI;
      end else if (done) begin
        line_tag  <= req_tag;
        line_data <= ld_done ? msg2_data : req_data;
        line_mesi <= ld_done ? mesi_send : MM;
      end
      if (accept) begin
        req_store <= core_req_store;
        req_tag   <= core_req_tag;
        req_data  <= core_req_store ? core_req_data : '0;
      end
    end
  end

  logic [MSG_WIDTH-1:0]  q_type [2];
  logic [DATA_WIDTH-1:0] q_data [2];
  logic [TAG_WIDTH-1:0]  q_tag  [2];
  logic                  q_rd;
  logic [1:0]            q_cnt;
  logic                  full, pop, push_ok, q_wr;
  logic [MSG_WIDTH-1:0]  ack_type;
  logic [DATA_WIDTH-1:0] ack_data;

  assign ack_type = ld_fwd ? LOAD_FA :
                    st_fwd ? STORE_FA : INV_FA;
  assign ack_data = (fwd_hit && !inv_fwd) ? line_data : '0;
  assign full     = q_cnt == 2'd2;
  assign pop      = msg3_grant && q_cnt != 2'd0;
  assign push_ok  = fwd && (!full || pop);
  assign q_wr     = q_rd ^ q_cnt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd    <= 1'b0;
      q_cnt   <= 2'd0;
      ack_ovf <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_type[i] <= NONE;
        q_data[i] <= '0;
        q_tag[i]  <= '0;
      end
    end else begin
      if (push_ok) begin
        q_type[q_wr] <= ack_type;
        q_data[q_wr] <= ack_data;
        q_tag[q_wr]  <= msg2_tag;
      end
      if (pop) q_rd <= ~q_rd;
      q_cnt <= q_cnt + 2'(push_ok) - 2'(pop);
      if (fwd && full && !pop) ack_ovf <= 1'b1;
    end
  end

  assign msg3_type   = (q_cnt != 2'd0) ? q_type[q_rd] : NONE;
  assign msg3_data   = (q_cnt != 2'd0) ? q_data[q_rd] : '0;
  assign msg3_tag    = (q_cnt != 2'd0) ? q_tag[q_rd]  : '0;
  assign msg3_source = (q_cnt != 2'd0) ? ID : '0;

endmodule

// File: tb/tb_l15_coherence_agent.sv
// Bench for l15_coherence_agent: directed scenarios plus random
// traffic checked against a line/ack-queue reference model.
module tb_l15_coherence_agent;

  localparam logic [3:0] NONE      = 4'd0;
  localparam logic [3:0] LOAD_REQ  = 4'd1;
  localparam logic [3:0] STORE_REQ = 4'd2;
  localparam logic [3:0] WB_REQ    = 4'd3;
  localparam logic [3:0] LOAD_ACK  = 4'd4;
  localparam logic [3:0] STORE_ACK = 4'd5;
  localparam logic [3:0] WB_ACK    = 4'd6;
  localparam logic [3:0] LOAD_FWD  = 4'd7;
  localparam logic [3:0] STORE_FWD = 4'd8;
  localparam logic [3:0] INV_FWD   = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_req_ready, core_req_store;
  logic [15:0] core_req_tag;
  logic [63:0] core_req_data;
  logic        core_resp_valid;
  logic [63:0] core_resp_data;
  logic [3:0]  msg1_type;
  logic [63:0] msg1_data;
  logic [15:0] msg1_tag;
  logic [2:0]  msg1_source;
  logic [3:0]  msg2_type;
  logic [63:0] msg2_data;
  logic [15:0] msg2_tag;
  logic [1:0]  mesi_send;
  logic [2:0]  cache_owner;
  logic [7:0]  share_list;
  logic [3:0]  msg3_type;
  logic [63:0] msg3_data;
  logic [15:0] msg3_tag;
  logic [2:0]  msg3_source;
  logic        msg3_grant;
  logic        ack_ovf;

  always #5 clk = ~clk;

  l15_coherence_agent dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid),
    .core_req_ready(core_req_ready),
    .core_req_store(core_req_store),
    .core_req_tag(core_req_tag),
    .core_req_data(core_req_data),
    .core_resp_valid(core_resp_valid),
    .core_resp_data(core_resp_data),
    .msg1_type(msg1_type), .msg1_data(msg1_data),
    .msg1_tag(msg1_tag), .msg1_source(msg1_source),
    .msg2_type(msg2_type), .msg2_data(msg2_data),
    .msg2_tag(msg2_tag), .mesi_send(mesi_send),
    .cache_owner(cache_owner), .share_list(share_list),
    .msg3_type(msg3_type), .msg3_data(msg3_data),
    .msg3_tag(msg3_tag), .msg3_source(msg3_source),
    .msg3_grant(msg3_grant), .ack_ovf(ack_ovf)
  );

  typedef struct {
    logic [3:0]  t;
    logic [63:0] d;
    logic [15:0] g;
  } ack_t;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_tag;
  logic [1:0]  m_mesi;
  logic [63:0] m_data;
  bit          m_ovf;
  ack_t        q[$];

  logic [15:0] tags [3] = '{16'h10, 16'h20, 16'h30};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_valid = 0; core_req_store = 0;
    core_req_tag = '0; core_req_data = '0;
    msg2_type = NONE; msg2_data = '0; msg2_tag = '0;
    mesi_send = '0; cache_owner = '0; share_list = '0;
    msg3_grant = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    m_tag = '0; m_mesi = 2'd0; m_data = '0;
    m_ovf = 0;
    q.delete();
  endtask

  task automatic check_head(input string nm);
    logic [86:0] exp;
    exp = '0;
    if (q.size() > 0) exp = {q[0].t, q[0].g, q[0].d, 3'd0};
    tests++;
    if ({msg3_type, msg3_tag, msg3_data, msg3_source} !== exp) begin
      fails++;
      $display("FAIL %s msg3 got %0h/%0h/%0h/%0h want %0h",
        nm, msg3_type, msg3_tag, msg3_data, msg3_source, exp);
    end
    tests++;
    if (ack_ovf !== m_ovf) begin
      fails++;
      $display("FAIL %s ack_ovf got %0b want %0b",
        nm, ack_ovf, m_ovf);
    end
  endtask

  task automatic fwd_cycle(input logic [3:0] t,
                           input logic [15:0] tg,
                           input logic [2:0] own,
                           input logic [7:0] sl,
                           input bit idle, input bit g);
    bit acc, hit;
    ack_t e;
    acc = ((t == LOAD_FWD || t == STORE_FWD) && own == 3'd0) ||
          (t == INV_FWD && sl[0]);
    msg2_type = t; msg2_tag = tg; msg2_data = {$urandom, $urandom};
    cache_owner = own; share_list = sl; msg3_grant = g;
    #1;
    tests++;
    if (core_req_ready !== (idle && !acc)) begin
      fails++;
      $display("FAIL fwd_ready got %0b want %0b",
        core_req_ready, idle && !acc);
    end
    tick();
    msg2_type = NONE; cache_owner = '0; share_list = '0;
    msg3_grant = 0;
    if (g && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      hit = tg == m_tag && m_mesi != 2'd0;
      e.t = t + 4'd3;
      e.d = (hit && t != INV_FWD) ? m_data : 64'd0;
      e.g = tg;
      if (q.size() < 2) q.push_back(e);
      else m_ovf = 1;
      if (hit) m_mesi = (t == LOAD_FWD) ? 2'd1 : 2'd0;
    end
    check_head("fwd");
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      check_head("drain");
      msg3_grant = 1;
      tick();
      msg3_grant = 0;
      void'(q.pop_front());
    end
    check_head("drained");
  endtask

  task automatic rand_fwd(input bit idle);
    logic [3:0] t;
    logic [15:0] tg;
    t = 4'(7 + $urandom_range(0, 2));
    tg = ($urandom_range(0, 2) != 0) ? m_tag : tags[$urandom_range(0, 2)];
    fwd_cycle(t, tg, 3'd0, 8'h01, idle, 0);
  endtask

  task automatic core_op(input bit st, input logic [15:0] tg,
                         input logic [63:0] d,
                         input logic [63:0] ad,
                         input logic [1:0] am, input bit inject);
    bit hit;
    logic [63:0] exp;
    hit = tg == m_tag && m_mesi != 2'd0;
    core_req_valid = 1; core_req_store = st;
    core_req_tag = tg; core_req_data = d;
    #1;
    tests++;
    if (core_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_ready got %0b want 1", core_req_ready);
    end
    tick();
    core_req_valid = 0;
    if (hit && (!st || m_mesi >= 2'd2)) begin
      exp = st ? d : m_data;
      tests++;
      if ({core_resp_valid, core_resp_data, msg1_type} !==
          {1'b1, exp, NONE}) begin
        fails++;
        $display("FAIL hit_resp got %0b/%0h/%0h want 1/%0h/0",
          core_resp_valid, core_resp_data, msg1_type, exp);
      end
      if (st) begin m_data = d; m_mesi = 2'd3; end
    end else begin
      if (tg != m_tag && m_mesi == 2'd3) begin
        tests++;
        if ({msg1_type, msg1_tag, msg1_data, msg1_source} !==
            {WB_REQ, m_tag, m_data, 3'd0}) begin
          fails++;
          $display("FAIL wb_req got %0h/%0h/%0h want 3/%0h/%0h",
            msg1_type, msg1_tag, msg1_data, m_tag, m_data);
        end
        tick();
        tests++;
        if (msg1_type !== NONE) begin
          fails++;
          $display("FAIL wb_pulse got %0h want 0", msg1_type);
        end
        if (inject) begin rand_fwd(0); drain(); end
        repeat ($urandom_range(0, 2)) tick();
        msg2_type = WB_ACK; msg2_tag = m_tag; cache_owner = 3'd0;
        tick();
        msg2_type = NONE;
        m_mesi = 2'd0;
      end
      tests++;
      if ({msg1_type, msg1_tag, msg1_data, msg1_source,
           core_resp_valid} !==
          {st ? STORE_REQ : LOAD_REQ, tg, st ? d : 64'd0,
           3'd0, 1'b0}) begin
        fails++;
        $display("FAIL req_msg got %0h/%0h/%0h want %0h/%0h/%0h",
          msg1_type, msg1_tag, msg1_data,
          st ? STORE_REQ : LOAD_REQ, tg, st ? d : 64'd0);
      end
      tick();
      tests++;
      if (msg1_type !== NONE) begin
        fails++;
        $display("FAIL req_pulse got %0h want 0", msg1_type);
      end
      if (inject) begin rand_fwd(0); drain(); end
      msg2_type = LOAD_ACK; msg2_tag = tg ^ 16'h0001;
      msg2_data = {$urandom, $urandom}; cache_owner = 3'd0;
      tick();
      tests++;
      if (core_resp_valid !== 1'b0) begin
        fails++;
        $display("FAIL stale_ack got %0b want 0", core_resp_valid);
      end
      msg2_type = st ? STORE_ACK : LOAD_ACK; msg2_tag = tg;
      msg2_data = ad; mesi_send = am;
      tick();
      msg2_type = NONE;
      exp = st ? d : ad;
      tests++;
      if ({core_resp_valid, core_resp_data} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL miss_resp got %0b/%0h want 1/%0h",
          core_resp_valid, core_resp_data, exp);
      end
      m_tag = tg; m_data = exp; m_mesi = st ? 2'd3 : am;
    end
    tick();
    tests++;
    if (core_resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL resp_pulse got %0b want 0", core_resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tests++;
    if ({core_req_ready, core_resp_valid, core_resp_data,
         msg1_type, msg1_tag, msg1_data, msg1_source,
         msg3_type, ack_ovf} !== '0) begin
      fails++;
      $display("FAIL reset outputs ready=%0b resp=%0b m1=%0h m3=%0h",
        core_req_ready, core_resp_valid, msg1_type, msg3_type);
    end
    do_reset();
  endtask

  task automatic test_load_miss();
    core_op(0, 16'h10, 64'd0, 64'hAA, 2'd2, 0);
    core_op(0, 16'h10, 64'd0, 64'd0, 2'd0, 0);
  endtask

  task automatic test_store_fwd();
    core_op(1, 16'h10, 64'h55, 64'd0, 2'd0, 0);
    fwd_cycle(LOAD_FWD, 16'h10, 3'd0, 8'h00, 1, 0);
    drain();
  endtask

  task automatic test_writeback();
    core_op(1, 16'h10, 64'h77, 64'd0, 2'd0, 0);
    core_op(0, 16'h20, 64'd0, 64'h1234, 2'd2, 0);
  endtask

  task automatic test_inv();
    fwd_cycle(INV_FWD, 16'h20, 3'd0, 8'h02, 1, 0);
    fwd_cycle(INV_FWD, 16'h20, 3'd5, 8'h01, 1, 0);
    drain();
    core_op(0, 16'h20, 64'd0, 64'h99, 2'd1, 0);
  endtask

  task automatic test_back_to_back();
    core_op(0, 16'h30, 64'd0, 64'hBEEF, 2'd2, 0);
    fwd_cycle(LOAD_FWD, 16'h30, 3'd0, 8'h00, 1, 0);
    fwd_cycle(STORE_FWD, 16'h30, 3'd0, 8'h00, 1, 0);
    fwd_cycle(INV_FWD, 16'h30, 3'd2, 8'h01, 1, 1);
    fwd_cycle(LOAD_FWD, 16'h20, 3'd0, 8'h00, 1, 1);
    drain();
  endtask

  task automatic test_overflow();
    core_op(0, 16'h40, 64'd0, 64'hC0FFEE, 2'd3, 0);
    fwd_cycle(LOAD_FWD, 16'h40, 3'd0, 8'h00, 1, 0);
    fwd_cycle(LOAD_FWD, 16'h41, 3'd0, 8'h00, 1, 0);
    fwd_cycle(STORE_FWD, 16'h40, 3'd0, 8'h00, 1, 0);
    tests++;
    if ({ack_ovf, q.size() == 2} !== 2'b11) begin
      fails++;
      $display("FAIL overflow ack_ovf got %0b want 1", ack_ovf);
    end
    drain();
  endtask

  task automatic test_collision();
    core_op(0, 16'h50, 64'd0, 64'h5050, 2'd2, 0);
    core_req_valid = 1; core_req_store = 0;
    core_req_tag = 16'h50;
    fwd_cycle(STORE_FWD, 16'h50, 3'd0, 8'h00, 1, 0);
    core_op(0, 16'h50, 64'd0, 64'h6060, 2'd1, 0);
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_req_valid = 1; core_req_store = 0;
    core_req_tag = 16'h0ABC;
    tick();
    core_req_valid = 0;
    tests++;
    if (msg1_type !== LOAD_REQ) begin
      fails++;
      $display("FAIL mid_req got %0h want 1", msg1_type);
    end
    tick();
    do_reset();
    msg2_type = LOAD_ACK; msg2_tag = 16'h0ABC;
    msg2_data = 64'h1234; mesi_send = 2'd2; cache_owner = 3'd0;
    tick();
    msg2_type = NONE;
    tests++;
    if ({core_resp_valid, msg1_type} !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset got %0b/%0h want 0/0",
        core_resp_valid, msg1_type);
    end
    core_op(0, 16'h0ABC, 64'd0, 64'h4321, 2'd2, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        core_op($urandom_range(0, 1) == 1,
                tags[$urandom_range(0, 2)],
                {$urandom, $urandom}, {$urandom, $urandom},
                2'($urandom_range(1, 3)),
                $urandom_range(0, 1) == 1);
        drain();
      end else begin
        fwd_cycle(4'(7 + $urandom_range(0, 2)),
                  tags[$urandom_range(0, 2)],
                  3'($urandom_range(0, 1)),
                  8'($urandom), 1, 0);
        drain();
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_load_miss();
    test_store_fwd();
    test_writeback();
    test_inv();
    test_back_to_back();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
